// File: rtl/lzy_cmp_seq.sv
// Sequential max/min finder over four sign-magnitude operands, sharing one
// signed compare unit between the max and min searches.
module lzy_cmp_seq (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       START,
    input  logic [3:0] DIN,
    input  logic       DIN_VLD,
    output logic       DIN_RDY,
    output logic       BUSY,
    output logic       DONE,
    output logic [3:0] MAX,
    output logic [3:0] MIN,
    output logic [1:0] MAX_IDX,
    output logic [1:0] MIN_IDX,
    output logic       ALL_EQ
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CMP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state_q;
    logic [1:0]  load_cnt_q;
    logic [2:0]  step_q;
    logic [3:0]  op_q [4];
    logic [3:0]  cur_max_q, cur_min_q;
    logic [1:0]  max_idx_q, min_idx_q;
    logic [3:0]  cur_max_d, cur_min_d;
    logic [1:0]  max_idx_d, min_idx_d;
    logic        din_rdy_q, busy_q, done_q;
    logic [3:0]  max_q, min_q;
    logic [1:0]  max_o_idx_q, min_o_idx_q;
    logic        all_eq_q;

    logic [1:0]  cmp_idx;
    logic [3:0]  cmp_a, cmp_b;
    logic [4:0]  cmp_diff;
    logic        a_gt_b, a_lt_b;

    // Code 1000 is the most negative value, not a negative zero.
    function automatic logic [3:0] sm_to_tc(input logic [3:0] c);
        logic [3:0] r;
        if (!c[3])
            r = c;
        else if (c[2:0] == 3'd0)
            r = 4'b1000;
        else
            r = 4'd0 - {1'b0, c[2:0]};
        return r;
    endfunction

    // The single compare unit: one subtractor, shared by both searches.
    always_comb begin
        cmp_idx   = 2'd1 + step_q[2:1];
        cmp_a     = sm_to_tc(op_q[cmp_idx]);
        cmp_b     = step_q[0] ? sm_to_tc(cur_min_q) : sm_to_tc(cur_max_q);
        cmp_diff  = {cmp_a[3], cmp_a} - {cmp_b[3], cmp_b};
        a_lt_b    = cmp_diff[4];
        a_gt_b    = !cmp_diff[4] && (cmp_diff != 5'd0);
        cur_max_d = cur_max_q;
        cur_min_d = cur_min_q;
        max_idx_d = max_idx_q;
        min_idx_d = min_idx_q;
        if (!step_q[0] && a_gt_b) begin
            cur_max_d = op_q[cmp_idx];
            max_idx_d = cmp_idx;
        end
        if (step_q[0] && a_lt_b) begin
            cur_min_d = op_q[cmp_idx];
            min_idx_d = cmp_idx;
        end
    end

    // Operand storage needs no reset; it is always written before use.
    always_ff @(posedge CLK) begin
        if (state_q == S_LOAD && DIN_VLD)
            op_q[load_cnt_q] <= DIN;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= S_IDLE;
            load_cnt_q  <= 2'd0;
            step_q      <= 3'd0;
            cur_max_q   <= 4'd0;
            cur_min_q   <= 4'd0;
            max_idx_q   <= 2'd0;
            min_idx_q   <= 2'd0;
            din_rdy_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            max_q       <= 4'd0;
            min_q       <= 4'd0;
            max_o_idx_q <= 2'd0;
            min_o_idx_q <= 2'd0;
            all_eq_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (START) begin
                        state_q    <= S_LOAD;
                        load_cnt_q <= 2'd0;
                        din_rdy_q  <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (DIN_VLD) begin
                        load_cnt_q <= load_cnt_q + 2'd1;
                        if (load_cnt_q == 2'd3) begin
                            state_q   <= S_CMP;
                            din_rdy_q <= 1'b0;
                            step_q    <= 3'd0;
                            cur_max_q <= op_q[0];
                            cur_min_q <= op_q[0];
                            max_idx_q <= 2'd0;
                            min_idx_q <= 2'd0;
                        end
                    end
                end
                S_CMP: begin
                    cur_max_q <= cur_max_d;
                    cur_min_q <= cur_min_d;
                    max_idx_q <= max_idx_d;
                    min_idx_q <= min_idx_d;
                    if (step_q == 3'd5) begin
                        state_q     <= S_DONE;
                        step_q      <= 3'd0;
                        done_q      <= 1'b1;
                        max_q       <= cur_max_d;
                        min_q       <= cur_min_d;
                        max_o_idx_q <= max_idx_d;
                        min_o_idx_q <= min_idx_d;
                        // Mapping is one-to-one, so equal values means equal codes.
                        all_eq_q    <= (cur_max_d == cur_min_d);
                    end else begin
                        step_q <= step_q + 3'd1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q   <= S_IDLE;
                    din_rdy_q <= 1'b0;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b0;
                end
            endcase
        end
    end

    assign DIN_RDY = din_rdy_q;
    assign BUSY    = busy_q;
    assign DONE    = done_q;
    assign MAX     = max_q;
    assign MIN     = min_q;
    assign MAX_IDX = max_o_idx_q;
    assign MIN_IDX = min_o_idx_q;
    assign ALL_EQ  = all_eq_q;

endmodule
